// File: rtl/msu_sq_sequencer.sv
// Iteration controller for the MSU's 8-cycle modular squarer: job intake, run/stop, abort, checkpoints.
// Defining MSU_SEQ_WATCHDOG_EN adds a stall watchdog that aborts a RUN with no sq_valid for WDOG_CYCLES.
module msu_sq_sequencer #(
    parameter int T_LEN         = 64,
    parameter int CKPT_INTERVAL = 0,
    parameter int WDOG_CYCLES   = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [T_LEN-1:0] cmd_t_start,
    input  logic [T_LEN-1:0] cmd_t_final,
    input  logic             abort,
    output logic             sq_rst,
    output logic             sq_start,
    input  logic             sq_valid,
    output logic             sq_capture,
    output logic             ckpt_valid,
    input  logic             ckpt_ready,
    output logic [T_LEN-1:0] ckpt_t,
    output logic             ckpt_overrun,
    output logic             done,
    output logic             done_aborted,
    output logic [T_LEN-1:0] t_current
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_FINISH,
        S_ABORT
    } state_t;

    localparam bit               CKPT_EN     = (CKPT_INTERVAL > 0);
    localparam logic [T_LEN-1:0] CKPT_RELOAD = CKPT_EN ? T_LEN'(CKPT_INTERVAL - 1) : '0;

    state_t           r_state;
    logic             r_cmd_ready;
    logic             r_sq_rst;
    logic             r_sq_start;
    logic             r_done;
    logic             r_done_aborted;
    logic             r_ckpt_valid;
    logic             r_ckpt_overrun;
    logic [T_LEN-1:0] r_ckpt_t;
    logic [T_LEN-1:0] r_ckpt_cnt;
    logic [T_LEN-1:0] r_t_current;
    logic [T_LEN-1:0] r_t_final;

    logic             w_at_final;
    logic             w_wdog_trip;
    logic             w_count;
    logic             w_capture;

    assign w_at_final = (r_t_current == r_t_final);

    // A squaring counts only in RUN when neither finish nor any abort source takes priority.
    assign w_count   = !reset && (r_state == S_RUN) && !w_at_final && !abort && !w_wdog_trip && sq_valid;
    assign w_capture = CKPT_EN && w_count && (r_ckpt_cnt == '0);

`ifdef MSU_SEQ_WATCHDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

    logic [WDOG_W-1:0] r_wdog_cnt;

    // Held at zero outside RUN, so entering RUN always starts a fresh count.
    always_ff @(posedge clk) begin
        if (reset || sq_valid || r_state != S_RUN) begin
            r_wdog_cnt <= '0;
        end else begin
            r_wdog_cnt <= r_wdog_cnt + WDOG_W'(1);
        end
    end

    assign w_wdog_trip = (r_state == S_RUN) && !sq_valid && (r_wdog_cnt == WDOG_W'(WDOG_CYCLES - 1));
`else
    assign w_wdog_trip = 1'b0;
`endif

    // NOTE: all state lives in clocked blocks with non-blocking assignments, so every
    // branch reads the pre-edge values and the order of statements inside cannot race.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_cmd_ready    <= 1'b1;
            r_sq_rst       <= 1'b1;
            r_sq_start     <= 1'b0;
            r_done         <= 1'b0;
            r_done_aborted <= 1'b0;
            r_ckpt_valid   <= 1'b0;
            r_ckpt_overrun <= 1'b0;
            r_ckpt_t       <= '0;
            r_ckpt_cnt     <= '0;
            r_t_current    <= '0;
            r_t_final      <= '0;
        end else begin
            r_sq_start     <= 1'b0;
            r_done         <= 1'b0;
            r_done_aborted <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_t_current    <= cmd_t_start;
                        r_t_final      <= cmd_t_final;
                        r_ckpt_cnt     <= CKPT_RELOAD;
                        r_ckpt_overrun <= 1'b0;
                        r_cmd_ready    <= 1'b0;
                        r_sq_rst       <= 1'b0;
                        r_sq_start     <= 1'b1;
                        r_state        <= S_START;
                    end
                end
                S_START: begin
                    if (abort) begin
                        r_done         <= 1'b1;
                        r_done_aborted <= 1'b1;
                        r_sq_rst       <= 1'b1;
                        r_state        <= S_ABORT;
                    end else begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_at_final) begin
                        r_done  <= 1'b1;
                        r_state <= S_FINISH;
                    end else if (abort || w_wdog_trip) begin
                        r_done         <= 1'b1;
                        r_done_aborted <= 1'b1;
                        r_sq_rst       <= 1'b1;
                        r_state        <= S_ABORT;
                    end else if (sq_valid) begin
                        r_t_current <= r_t_current + T_LEN'(1);
                        if (CKPT_EN) begin
                            r_ckpt_cnt <= (r_ckpt_cnt == '0) ? CKPT_RELOAD : r_ckpt_cnt - T_LEN'(1);
                        end
                    end
                end
                S_FINISH: begin
                    r_sq_rst    <= 1'b1;
                    r_cmd_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
                S_ABORT: begin
                    r_cmd_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_sq_rst    <= 1'b1;
                    r_cmd_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase

            // A new capture replaces any pending checkpoint; a simultaneous handshake is not an overrun.
            if (w_capture) begin
                r_ckpt_valid <= 1'b1;
                r_ckpt_t     <= r_t_current + T_LEN'(1);
                if (r_ckpt_valid && !ckpt_ready) begin
                    r_ckpt_overrun <= 1'b1;
                end
            end else if (r_ckpt_valid && ckpt_ready) begin
                r_ckpt_valid <= 1'b0;
            end
        end
    end

    // sq_capture is combinational so the host latches sq_out alongside the sq_valid that produced it.
    assign sq_capture   = w_capture;
    assign cmd_ready    = r_cmd_ready;
    assign sq_rst       = r_sq_rst;
    assign sq_start     = r_sq_start;
    assign ckpt_valid   = r_ckpt_valid;
    assign ckpt_t       = r_ckpt_t;
    assign ckpt_overrun = r_ckpt_overrun;
    assign done         = r_done;
    assign done_aborted = r_done_aborted;
    assign t_current    = r_t_current;

endmodule

// File: tb/tb_msu_sq_sequencer.sv
// Self-checking bench for msu_sq_sequencer: directed jobs plus randomized jobs against a job-level model.
// A second instance with checkpoints disabled runs the same stimulus.
module tb_msu_sq_sequencer;

    localparam int TL = 8;
    localparam int CI = 4;
    localparam int WD = 20;

    logic          clk;
    logic          reset;
    logic          cmd_valid;
    logic [TL-1:0] cmd_t_start;
    logic [TL-1:0] cmd_t_final;
    logic          abort;
    logic          sq_valid;
    logic          ckpt_ready;

    logic          cmd_ready, sq_rst, sq_start, sq_capture, ckpt_valid, ckpt_overrun, done, done_aborted;
    logic [TL-1:0] ckpt_t, t_current;

    logic          nk_cmd_ready, nk_sq_rst, nk_sq_start, nk_sq_capture, nk_ckpt_valid, nk_ckpt_overrun;
    logic          nk_done, nk_done_aborted;
    logic [TL-1:0] nk_ckpt_t, nk_t_current;

    int n_cmp = 0;
    int n_bad = 0;

    // Job-level model of the checkpoint channel.
    bit            m_pend = 1'b0;
    bit            m_ovr  = 1'b0;
    logic [TL-1:0] m_ckpt_t = '0;

    msu_sq_sequencer #(.T_LEN(TL), .CKPT_INTERVAL(CI), .WDOG_CYCLES(WD)) u_dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_t_start(cmd_t_start), .cmd_t_final(cmd_t_final), .abort(abort),
        .sq_rst(sq_rst), .sq_start(sq_start), .sq_valid(sq_valid), .sq_capture(sq_capture),
        .ckpt_valid(ckpt_valid), .ckpt_ready(ckpt_ready), .ckpt_t(ckpt_t),
        .ckpt_overrun(ckpt_overrun), .done(done), .done_aborted(done_aborted), .t_current(t_current)
    );

    msu_sq_sequencer #(.T_LEN(TL), .CKPT_INTERVAL(0), .WDOG_CYCLES(WD)) u_nock (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(nk_cmd_ready),
        .cmd_t_start(cmd_t_start), .cmd_t_final(cmd_t_final), .abort(abort),
        .sq_rst(nk_sq_rst), .sq_start(nk_sq_start), .sq_valid(sq_valid), .sq_capture(nk_sq_capture),
        .ckpt_valid(nk_ckpt_valid), .ckpt_ready(ckpt_ready), .ckpt_t(nk_ckpt_t),
        .ckpt_overrun(nk_ckpt_overrun), .done(nk_done), .done_aborted(nk_done_aborted),
        .t_current(nk_t_current)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int k);
        repeat (k) step();
    endtask

    // One job: n = (f - s) mod 2^TL squarings, optional abort before squaring abort_at,
    // random gap of [gmin,gmax] idle RUN cycles before each sq_valid.
    task automatic run_job(input logic [TL-1:0] s, input logic [TL-1:0] f, input int abort_at,
                           input int gmin, input int gmax, input bit rdy);
        logic [TL-1:0] d;
        logic [TL-1:0] exp_t;
        int            n;
        bit            aborted;
        bit            cap;
        d       = f - s;
        n       = int'(d);
        exp_t   = s;
        aborted = 1'b0;

        check("cmd_ready before job", cmd_ready, 1);
        cmd_t_start = s;
        cmd_t_final = f;
        cmd_valid   = 1'b1;
        ckpt_ready  = rdy;
        step();
        cmd_valid = 1'b0;
        if (rdy) m_pend = 1'b0;
        m_ovr = 1'b0;
        check("sq_start in START", sq_start, 1);
        check("sq_rst in START", sq_rst, 0);
        check("cmd_ready busy", cmd_ready, 0);
        step();
        check("sq_start single pulse", sq_start, 0);

        for (int c = 0; c < n && !aborted; c++) begin
            idle($urandom_range(gmax, gmin));
            if (c == abort_at) begin
                abort    = 1'b1;
                sq_valid = 1'($urandom_range(1, 0));
                #1;
                check("no capture on abort", sq_capture, 0);
                step();
                abort    = 1'b0;
                sq_valid = 1'b0;
                check("abort done", done, 1);
                check("abort done_aborted", done_aborted, 1);
                check("abort sq_rst", sq_rst, 1);
                check("abort t_current", t_current, exp_t);
                check("nock abort t_current", nk_t_current, exp_t);
                aborted = 1'b1;
            end else begin
                sq_valid = 1'b1;
                #1;
                exp_t = exp_t + 1'b1;
                cap   = ((c + 1) % CI == 0);
                check("sq_capture", sq_capture, cap);
                check("nock sq_capture", nk_sq_capture, 0);
                step();
                sq_valid = 1'b0;
                check("t_current step", t_current, exp_t);
                check("no early done", done, 0);
                if (cap) begin
                    if (m_pend && !rdy) m_ovr = 1'b1;
                    m_pend   = 1'b1;
                    m_ckpt_t = exp_t;
                    check("ckpt_valid after capture", ckpt_valid, 1);
                    check("ckpt_t after capture", ckpt_t, exp_t);
                end
            end
        end

        if (!aborted) begin
            // Final count reached: a coincident abort loses, a coincident sq_valid is ignored.
            abort    = 1'($urandom_range(1, 0));
            sq_valid = 1'b1;
            #1;
            check("no capture at final", sq_capture, 0);
            step();
            abort    = 1'b0;
            sq_valid = 1'b0;
            check("finish done", done, 1);
            check("finish done_aborted", done_aborted, 0);
            check("finish t_current", t_current, f);
            check("nock finish done", nk_done, 1);
            check("nock finish t_current", nk_t_current, f);
        end

        step();
        check("done single pulse", done, 0);
        check("cmd_ready after job", cmd_ready, 1);
        check("sq_rst after job", sq_rst, 1);
        if (rdy) m_pend = 1'b0;
        idle(1);
        check("ckpt_valid after job", ckpt_valid, m_pend);
        check("ckpt_t after job", ckpt_t, m_ckpt_t);
        check("ckpt_overrun after job", ckpt_overrun, m_ovr);
        check("nock ckpt_valid", nk_ckpt_valid, 0);
    endtask

    initial begin
        reset       = 1'b1;
        cmd_valid   = 1'b0;
        cmd_t_start = '0;
        cmd_t_final = '0;
        abort       = 1'b0;
        sq_valid    = 1'b0;
        ckpt_ready  = 1'b0;
        idle(2);
        reset = 1'b0;

        check("reset cmd_ready", cmd_ready, 1);
        check("reset sq_rst", sq_rst, 1);
        check("reset sq_start", sq_start, 0);
        check("reset sq_capture", sq_capture, 0);
        check("reset ckpt_valid", ckpt_valid, 0);
        check("reset ckpt_overrun", ckpt_overrun, 0);
        check("reset done", done, 0);
        check("reset done_aborted", done_aborted, 0);
        check("reset t_current", t_current, 0);
        check("reset ckpt_t", ckpt_t, 0);

        // Zero-length job, normal 8-cycle cadence, checkpoints with and without consumption.
        run_job(8'd5, 8'd5, -1, 0, 0, 1'b1);
        run_job(8'd0, 8'd10, -1, 7, 7, 1'b1);
        run_job(8'd0, 8'd12, -1, 0, 3, 1'b1);
        run_job(8'd0, 8'd12, -1, 0, 3, 1'b0);
        ckpt_ready = 1'b1;
        step();
        m_pend = 1'b0;
        check("ckpt drained", ckpt_valid, 0);
        check("overrun sticky in idle", ckpt_overrun, 1);

        // Abort in RUN at t_current=3, then abort during START.
        run_job(8'd0, 8'd10, 3, 0, 2, 1'b1);
        cmd_t_start = 8'd1;
        cmd_t_final = 8'd9;
        cmd_valid   = 1'b1;
        step();
        cmd_valid = 1'b0;
        abort     = 1'b1;
        check("START abort sq_start", sq_start, 1);
        step();
        abort = 1'b0;
        check("START abort done", done, 1);
        check("START abort done_aborted", done_aborted, 1);
        check("START abort sq_rst", sq_rst, 1);
        step();
        check("START abort back to idle", cmd_ready, 1);
        m_ovr = 1'b0;

        // Reset in the middle of a job.
        cmd_t_start = 8'd0;
        cmd_t_final = 8'd50;
        cmd_valid   = 1'b1;
        step();
        cmd_valid = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            sq_valid = 1'b1;
            step();
            sq_valid = 1'b0;
            step();
        end
        check("pre-reset t_current", t_current, 3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid-job reset sq_rst", sq_rst, 1);
        check("mid-job reset done", done, 0);
        check("mid-job reset cmd_ready", cmd_ready, 1);
        check("mid-job reset t_current", t_current, 0);
        m_pend   = 1'b0;
        m_ovr    = 1'b0;
        m_ckpt_t = '0;

        // Wrap-around job.
        run_job(8'd250, 8'd3, -1, 0, 2, 1'b1);

        // Randomized jobs.
        for (int j = 0; j < 24; j++) begin
            logic [TL-1:0] rs;
            logic [TL-1:0] rn;
            int            ab;
            rs = TL'($urandom);
            rn = TL'($urandom_range(14, 0));
            ab = ($urandom_range(3, 0) == 0) ? int'($urandom_range(14, 0)) : -1;
            run_job(rs, rs + rn, ab, 0, 3, 1'($urandom_range(1, 0)));
        end

        // Stall in RUN with no sq_valid.
        cmd_t_start = 8'd0;
        cmd_t_final = 8'd5;
        cmd_valid   = 1'b1;
        step();
        cmd_valid = 1'b0;
        step();
        for (int i = 1; i < WD; i++) begin
            step();
            check("no done during stall", done, 0);
        end
        step();
`ifdef MSU_SEQ_WATCHDOG_EN
        check("watchdog done", done, 1);
        check("watchdog done_aborted", done_aborted, 1);
`else
        check("no watchdog done", done, 0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("stall abort done", done, 1);
        check("stall abort done_aborted", done_aborted, 1);
`endif
        step();
        check("stall back to idle", cmd_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
